// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multicycle MIPS-subset core with an internal control FSM and a
// single shared valid/ready memory port (unified instruction/data memory).
// Supports add/sub/and/or/slt, lw, sw, beq, addi and j; any other opcode
// halts the core in a terminal trap state until reset.
// Build option: define MC_BNE_EN to add bne (op 0x05) as a supported branch.
module mc_cpu_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              trap,
    output logic [31:0]       instret
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef MC_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'h05;
`endif

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] aluout;
    logic [31:0] rf [32];

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm_sext;
    logic [31:0] jump_target;
    logic [31:0] addr_full;
    logic        funct_ok;
    logic        branch_taken;
    state_t      decode_next;
    alu_op_t     alu_ctl;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [31:0] alu_result;
    logic        alu_zero;

    assign op          = ir[31:26];
    assign rs          = ir[25:21];
    assign rt          = ir[20:16];
    assign rd          = ir[15:11];
    assign funct       = ir[5:0];
    assign imm_sext    = {{16{ir[15]}}, ir[15:0]};
    // pc already holds PC+4 once the instruction has been fetched.
    assign jump_target = {pc[31:28], ir[25:0], 2'b00};
    assign funct_ok    = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                         (funct == FN_OR)  || (funct == FN_SLT);

    // Operand and operation select for the shared ALU, by FSM state.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        alu_x   = a;
        alu_y   = b;
        alu_ctl = ALU_ADD;
        case (state)
            S_DECODE: begin
                alu_x = pc;
                alu_y = {imm_sext[29:0], 2'b00};
            end
            S_MEMADR, S_ADDIEX: alu_y = imm_sext;
            S_BRANCH: alu_ctl = ALU_SUB;
            S_EXEC: begin
                case (funct)
                    FN_SUB:  alu_ctl = ALU_SUB;
                    FN_AND:  alu_ctl = ALU_AND;
                    FN_OR:   alu_ctl = ALU_OR;
                    FN_SLT:  alu_ctl = ALU_SLT;
                    default: alu_ctl = ALU_ADD;
                endcase
            end
            default: ;
        endcase
    end

    // 32-bit ALU; slt compares as signed.
    always_comb begin
        alu_result = 32'd0;
        case (alu_ctl)
            ALU_ADD: alu_result = alu_x + alu_y;
            ALU_SUB: alu_result = alu_x - alu_y;
            ALU_AND: alu_result = alu_x & alu_y;
            ALU_OR:  alu_result = alu_x | alu_y;
            ALU_SLT: alu_result = {31'd0, $signed(alu_x) < $signed(alu_y)};
            default: alu_result = 32'd0;
        endcase
    end

    assign alu_zero = (alu_result == 32'd0);

    // Branch condition: beq on equal operands, bne (if built) on unequal ones.
    always_comb begin
        branch_taken = alu_zero;
`ifdef MC_BNE_EN
        if (op == OP_BNE) begin
            branch_taken = !alu_zero;
        end
`endif
    end

    // Opcode dispatch out of DECODE; anything unrecognised goes to TRAP.
    always_comb begin
        decode_next = S_TRAP;
        case (op)
            OP_RTYPE:     if (funct_ok) decode_next = S_EXEC;
            OP_LW, OP_SW: decode_next = S_MEMADR;
            OP_BEQ:       decode_next = S_BRANCH;
`ifdef MC_BNE_EN
            OP_BNE:       decode_next = S_BRANCH;
`endif
            OP_ADDI:      decode_next = S_ADDIEX;
            OP_J:         decode_next = S_JUMP;
            default:      decode_next = S_TRAP;
        endcase
    end

    // Memory port and status decode straight from the state register, so a
    // request is visible in the very cycle the FSM enters a memory state.
    assign mem_req   = !reset && ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR));
    assign mem_we    = (state == S_MEMWR);
    assign addr_full = (state == S_FETCH) ? pc : aluout;
    assign mem_addr  = addr_full[ADDR_W-1:0];
    assign mem_wdata = b;
    assign trap      = (state == S_TRAP);

    // Control FSM plus all datapath registers and the register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            ir      <= 32'd0;
            mdr     <= 32'd0;
            a       <= 32'd0;
            b       <= 32'd0;
            aluout  <= 32'd0;
            instret <= 32'd0;
            // NOTE: the register file is flop-based and must come up zeroed, so it
            // is cleared here; a RAM macro could not be reset this way.
            for (int i = 0; i < 32; i++) begin
                rf[i] <= 32'd0;
            end
        end else begin
            // NOTE: non-blocking assignments only, so every register samples pre-edge values.
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata;
                        pc    <= pc + 32'd4;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a      <= (rs == 5'd0) ? 32'd0 : rf[rs];
                    b      <= (rt == 5'd0) ? 32'd0 : rf[rt];
                    aluout <= alu_result;
                    state  <= decode_next;
                end
                S_MEMADR: begin
                    aluout <= alu_result;
                    state  <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    if (mem_ready) begin
                        mdr   <= mem_rdata;
                        state <= S_MEMWB;
                    end
                end
                S_MEMWB: begin
                    if (rt != 5'd0) rf[rt] <= mdr;
                    instret <= instret + 32'd1;
                    state   <= S_FETCH;
                end
                S_MEMWR: begin
                    if (mem_ready) begin
                        instret <= instret + 32'd1;
                        state   <= S_FETCH;
                    end
                end
                S_EXEC: begin
                    aluout <= alu_result;
                    state  <= S_ALUWB;
                end
                S_ALUWB: begin
                    if (rd != 5'd0) rf[rd] <= aluout;
                    instret <= instret + 32'd1;
                    state   <= S_FETCH;
                end
                S_ADDIEX: begin
                    aluout <= alu_result;
                    state  <= S_ADDIWB;
                end
                S_ADDIWB: begin
                    if (rt != 5'd0) rf[rt] <= aluout;
                    instret <= instret + 32'd1;
                    state   <= S_FETCH;
                end
                S_BRANCH: begin
                    if (branch_taken) pc <= aluout;
                    instret <= instret + 32'd1;
                    state   <= S_FETCH;
                end
                S_JUMP: begin
                    pc      <= jump_target;
                    instret <= instret + 32'd1;
                    state   <= S_FETCH;
                end
                S_TRAP:  state <= S_TRAP;
                default: state <= S_TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_cpu_core.sv
// Testbench for mc_cpu_core: a behavioural memory with programmable wait
// states, a scoreboard of expected memory transactions checked by a monitor,
// and directed programs covering ALU ops, loads/stores, branches, jumps,
// traps and reset during a pending write.
`timescale 1ns/1ps
module tb_mc_cpu_core;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        trap;
    logic [31:0] instret;

    logic [31:0] mem [256];
    txn_t        sb [$];
    int          wait_cfg;
    int          checks;
    int          failures;

    mc_cpu_core #(
        .RESET_PC (32'h0000_0100),
        .ADDR_W   (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .trap      (trap),
        .instret   (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic exp_fetch(input logic [31:0] addr);
        sb.push_back('{we: 1'b0, addr: addr, wdata: 32'd0});
    endtask

    task automatic exp_read(input logic [31:0] addr);
        sb.push_back('{we: 1'b0, addr: addr, wdata: 32'd0});
    endtask

    task automatic exp_write(input logic [31:0] addr, input logic [31:0] data);
        sb.push_back('{we: 1'b1, addr: addr, wdata: data});
    endtask

    // Memory responder: ready after wait_cfg wait cycles, writes commit only
    // once the handshake edge has passed outside reset.
    initial begin
        logic        cw;
        logic [7:0]  ci;
        logic [31:0] cd;
        int          wc;
        cw = 1'b0; ci = 8'd0; cd = 32'd0; wc = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_ready && !reset) begin
                if (cw) mem[ci] = cd;
                wc = 0;
            end
            mem_ready = 1'b0;
            if (reset || !mem_req) begin
                wc = 0;
            end else if (wc >= wait_cfg) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[9:2]];
                cw = mem_we;
                ci = mem_addr[9:2];
                cd = mem_wdata;
            end else begin
                wc++;
            end
        end
    end

    // Monitor: checks stability during waits and pops the scoreboard on each handshake.
    initial begin
        txn_t        e;
        logic        pend;
        logic [31:0] pa;
        logic [31:0] pw;
        logic        pwe;
        pend = 1'b0; pa = 32'd0; pw = 32'd0; pwe = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (pend && mem_req) begin
                    check("stable_addr", mem_addr, pa);
                    check("stable_we", 32'(mem_we), 32'(pwe));
                    check("stable_wdata", mem_wdata, pw);
                end
                if (mem_req && mem_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL txn_unexpected: got addr %h we %0d, expected no transaction", mem_addr, mem_we);
                    end else begin
                        e = sb.pop_front();
                        check("txn_addr", mem_addr, e.addr);
                        check("txn_we", 32'(mem_we), 32'(e.we));
                        if (e.we) check("txn_wdata", mem_wdata, e.wdata);
                    end
                end
                pend = mem_req && !mem_ready;
                pa   = mem_addr;
                pw   = mem_wdata;
                pwe  = mem_we;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'hFC00_0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_instret", instret, 32'd0);
        reset = 1'b0;
    endtask

    task automatic end_test(input string name);
        reset = 1'b1;
        check(name, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic run_until(input logic [31:0] target, input int budget, output int cycles);
        cycles = 0;
        while (instret !== target && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("instret_reach", instret, target);
    endtask

    task automatic wait_trap(input int budget, output int cycles);
        cycles = 0;
        while (trap !== 1'b1 && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("trap_set", 32'(trap), 32'd1);
    endtask

    task automatic load_prog_a();
        fill_mem();
        mem[64] = 32'h2001_0005; // 0x100 addi $1,$0,5
        mem[65] = 32'h2002_FFFD; // 0x104 addi $2,$0,-3
        mem[66] = 32'h0022_1820; // 0x108 add  $3,$1,$2
        mem[67] = 32'hAC03_0040; // 0x10C sw   $3,0x40($0)
        mem[68] = 32'h8C04_0040; // 0x110 lw   $4,0x40($0)
        mem[69] = 32'hAC04_0044; // 0x114 sw   $4,0x44($0)
        mem[70] = 32'h2005_FFFF; // 0x118 addi $5,$0,-1
        mem[71] = 32'h2006_0001; // 0x11C addi $6,$0,1
        mem[72] = 32'h00A6_382A; // 0x120 slt  $7,$5,$6
        mem[73] = 32'hAC07_0048; // 0x124 sw   $7,0x48($0)
        mem[74] = 32'h0022_4022; // 0x128 sub  $8,$1,$2
        mem[75] = 32'h0022_4824; // 0x12C and  $9,$1,$2
        mem[76] = 32'h0022_5025; // 0x130 or   $10,$1,$2
        mem[77] = 32'hAC08_004C; // 0x134 sw   $8,0x4C($0)
        mem[78] = 32'hAC09_0050; // 0x138 sw   $9,0x50($0)
        mem[79] = 32'hAC0A_0054; // 0x13C sw   $10,0x54($0)
        mem[80] = 32'h2000_0007; // 0x140 addi $0,$0,7
        mem[81] = 32'hAC00_0058; // 0x144 sw   $0,0x58($0)
        mem[82] = 32'h1022_0002; // 0x148 beq  $1,$2,+2 (not taken)
        mem[83] = 32'h0800_0058; // 0x14C j    0x160
        mem[88] = 32'h1021_FFFF; // 0x160 beq  $1,$1,-1 (self loop)
    endtask

    // Transactions of the first five instructions of program A.
    task automatic exp_prog_a_head();
        exp_fetch(32'h100); exp_fetch(32'h104); exp_fetch(32'h108);
        exp_fetch(32'h10C); exp_write(32'h40, 32'h2);
        exp_fetch(32'h110); exp_read(32'h40);
    endtask

    initial begin
        int c;
        checks   = 0;
        failures = 0;
        wait_cfg = 0;
        reset    = 1'b1;
        fill_mem();

        // Program A, zero wait states.
        load_prog_a();
        exp_prog_a_head();
        exp_fetch(32'h114); exp_write(32'h44, 32'h2);
        exp_fetch(32'h118); exp_fetch(32'h11C); exp_fetch(32'h120);
        exp_fetch(32'h124); exp_write(32'h48, 32'h1);
        exp_fetch(32'h128); exp_fetch(32'h12C); exp_fetch(32'h130);
        exp_fetch(32'h134); exp_write(32'h4C, 32'h8);
        exp_fetch(32'h138); exp_write(32'h50, 32'h5);
        exp_fetch(32'h13C); exp_write(32'h54, 32'hFFFF_FFFD);
        exp_fetch(32'h140); exp_fetch(32'h144); exp_write(32'h58, 32'h0);
        exp_fetch(32'h148); exp_fetch(32'h14C);
        for (int i = 0; i < 4; i++) exp_fetch(32'h160);
        do_reset();
        run_until(32'd5, 200, c);
        check("cycles_zero_wait", 32'(c), 32'd21);
        run_until(32'd21, 400, c);
        run_until(32'd24, 100, c);
        check("beq_loop_cycles", 32'(c), 32'd9);
        end_test("sb_drained_a");
        check("mem_0x40", mem[16], 32'h2);
        check("mem_0x44_lw", mem[17], 32'h2);
        check("mem_0x48_slt", mem[18], 32'h1);
        check("mem_0x54_or", mem[21], 32'hFFFF_FFFD);
        check("mem_0x58_r0", mem[22], 32'h0);

        // Program A head with 3 wait cycles on every request:
        // 7 memory requests x 3 wait cycles on top of 21 cycles.
        load_prog_a();
        wait_cfg = 3;
        exp_prog_a_head();
        do_reset();
        run_until(32'd5, 400, c);
        check("cycles_wait3", 32'(c), 32'd42);
        end_test("sb_drained_b");

        // Unsupported opcode traps after DECODE.
        fill_mem();
        wait_cfg = 0;
        mem[64] = 32'h2001_0001; // addi $1,$0,1
        mem[65] = 32'hFC00_0000; // op 0x3F
        exp_fetch(32'h100); exp_fetch(32'h104);
        do_reset();
        run_until(32'd1, 50, c);
        wait_trap(20, c);
        check("trap_cycles", 32'(c), 32'd2);
        begin
            logic req_seen;
            req_seen = 1'b0;
            repeat (10) begin
                @(posedge clk);
                #1;
                req_seen = req_seen | mem_req;
            end
            check("trap_no_req", 32'(req_seen), 32'd0);
        end
        check("trap_instret", instret, 32'd1);
        end_test("sb_drained_c");

        // bne on unequal operands.
        fill_mem();
        mem[64] = 32'h2001_0001; // 0x100 addi $1,$0,1
        mem[65] = 32'h1420_0002; // 0x104 bne  $1,$0,+2 -> 0x110
        mem[68] = 32'hAC01_0060; // 0x110 sw   $1,0x60($0)
        exp_fetch(32'h100); exp_fetch(32'h104);
`ifdef MC_BNE_EN
        exp_fetch(32'h110); exp_write(32'h60, 32'h1);
        do_reset();
        run_until(32'd3, 100, c);
        end_test("sb_drained_bne");
        check("bne_store", mem[24], 32'h1);
`else
        do_reset();
        run_until(32'd1, 50, c);
        wait_trap(20, c);
        check("bne_trap_instret", instret, 32'd1);
        end_test("sb_drained_bne");
`endif

        // Reset during a MEMWR wait abandons the store.
        fill_mem();
        wait_cfg = 3;
        mem[25] = 32'hDEAD_BEEF;
        mem[64] = 32'h2001_0009; // 0x100 addi $1,$0,9
        mem[65] = 32'hAC01_0064; // 0x104 sw   $1,0x64($0)
        exp_fetch(32'h100); exp_fetch(32'h104);
        do_reset();
        run_until(32'd1, 100, c);
        begin
            logic found;
            found = 1'b0;
            for (int i = 0; i < 30 && !found; i++) begin
                @(negedge clk);
                #2;
                found = mem_req && mem_we;
            end
            check("memwr_reached", 32'(found), 32'd1);
        end
        reset = 1'b1;
        #1;
        check("abort_mem_req", 32'(mem_req), 32'd0);
        check("abort_sb_drained", 32'(sb.size()), 32'd0);
        exp_fetch(32'h100);
        do_reset();
        c = 0;
        while (sb.size() != 0 && c < 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        end_test("restart_fetch");
        check("abort_no_write", mem[25], 32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
